merge_rr: RTL and testbench

Parametrised P-input dataflow merge for generated operator netlists, the successor to the two-input MERGE operator. Each input lane has its own FIFO, so tokens that arrive on several lanes in the same cycle are buffered and not lost. A round-robin arbiter emits at most one token per cycle on a registered R_OUT/D_OUT pair. The block sits wherever converging branches of the dataflow graph (for example, the two arms after a BEQI) rejoin ahead of a REG or the output port.

---
 rtl/merge_rr.sv | 184 ++++++++++++++++++
 tb/tb_merge_rr.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_rr.sv
// merge_rr: P-lane round-robin token merge with one FIFO per lane; T_OUT lane tag exists only with MERGE_RR_TAG_EN.
// Latency 2 cycles R_IN->R_OUT uncontended; no backpressure: a push into a full, unpopped FIFO is dropped and sets sticky OVF.

module merge_rr_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [N-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [N-1:0] head_dat_o,
    output logic         empty_o,
    output logic         ovf_o
);
    logic full;
    logic wr_en;

    // A full FIFO still accepts a push when its head leaves on the same edge.
    assign wr_en = push_i && (!full || pop_i);
    assign ovf_o = push_i && full && !pop_i;

    if (DEPTH == 1) begin : g_reg
        logic         vld_q;
        logic         vld_d;
        logic [N-1:0] dat_q;

        assign vld_d = wr_en ? 1'b1 : (pop_i ? 1'b0 : vld_q);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else begin
                vld_q <= vld_d;
                if (wr_en) dat_q <= push_dat_i;
            end
        end

        assign full       = vld_q;
        assign empty_o    = !vld_q;
        assign head_dat_o = dat_q;
    end else begin : g_ring
        localparam int AW = $clog2(DEPTH);
        logic [AW:0]  wr_q, wr_d;
        logic [AW:0]  rd_q, rd_d;
        logic [N-1:0] mem_q [DEPTH];

        assign wr_d = wr_en ? wr_q + 1'b1 : wr_q;
        assign rd_d = pop_i ? rd_q + 1'b1 : rd_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wr_q <= '0;
                rd_q <= '0;
            end else begin
                wr_q <= wr_d;
                rd_q <= rd_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (wr_en) mem_q[wr_q[AW-1:0]] <= push_dat_i;
        end

        assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        assign empty_o    = (wr_q == rd_q);
        assign head_dat_o = mem_q[rd_q[AW-1:0]];
    end
endmodule

module merge_rr #(
    parameter  int N     = 16,
    parameter  int P     = 2,
    parameter  int DEPTH = 2,
    localparam int TW    = ($clog2(P) > 1) ? $clog2(P) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic [P-1:0]   R_IN,
    input  logic [P*N-1:0] D_IN,
    output logic           R_OUT,
    output logic [N-1:0]   D_OUT,
    output logic           OVF
`ifdef MERGE_RR_TAG_EN
    ,
    output logic [TW-1:0]  T_OUT
`endif
);
    logic [P-1:0]  empty;
    logic [P-1:0]  push;
    logic [P-1:0]  pop;
    logic [P-1:0]  ovf_lane;
    logic [N-1:0]  head [P];
    logic [TW-1:0] win;
    logic          any;
    logic [TW-1:0] ptr_q, ptr_d;
    logic          r_out_q, r_out_d;
    logic [N-1:0]  d_out_q, d_out_d;
    logic          ovf_q, ovf_d;

    for (genvar i = 0; i < P; i++) begin : g_lane
        merge_rr_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
            .clk_i      (CLK),
            .rst_i      (RST),
            .push_i     (push[i]),
            .push_dat_i (D_IN[i*N +: N]),
            .pop_i      (pop[i]),
            .head_dat_o (head[i]),
            .empty_o    (empty[i]),
            .ovf_o      (ovf_lane[i])
        );
    end

    // Unrolled per pointer value so every lane index is a constant.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int s = 0; s < P; s++) begin
            if (ptr_q == TW'(s)) begin
                for (int k = 0; k < P; k++) begin
                    if (!any && !empty[(s + k) % P]) begin
                        any = 1'b1;
                        win = TW'((s + k) % P);
                    end
                end
            end
        end
    end

    always_comb begin
        push = '0;
        pop  = '0;
        for (int i = 0; i < P; i++) begin
            push[i] = EN && R_IN[i];
            pop[i]  = EN && any && (win == TW'(i));
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        r_out_d = 1'b0;
        d_out_d = d_out_q;
        ovf_d   = ovf_q | (|ovf_lane);
        if (EN && any) begin
            r_out_d = 1'b1;
            d_out_d = head[win];
            ptr_d   = (win == TW'(P - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q   <= '0;
            r_out_q <= 1'b0;
            d_out_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            r_out_q <= r_out_d;
            d_out_q <= d_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign R_OUT = r_out_q;
    assign D_OUT = d_out_q;
    assign OVF   = ovf_q;

`ifdef MERGE_RR_TAG_EN
    logic [TW-1:0] tag_q, tag_d;

    assign tag_d = (EN && any) ? win : tag_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) tag_q <= '0;
        else     tag_q <= tag_d;
    end

    assign T_OUT = tag_q;
`endif
endmodule

// File: tb/tb_merge_rr.sv
// Bench for merge_rr: cycle table on a 2-lane instance plus sequences on 2-, 4- and 3-lane instances.
module tb_merge_rr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_en = 1'b1;
    logic [1:0]  a_rin = '0;
    logic [31:0] a_din = '0;
    logic        a_rout, a_ovf;
    logic [15:0] a_dout;

    logic        b_en = 1'b1;
    logic [3:0]  b_rin = '0;
    logic [63:0] b_din = '0;
    logic        b_rout, b_ovf;
    logic [15:0] b_dout;

    logic        c_en = 1'b1;
    logic [2:0]  c_rin = '0;
    logic [47:0] c_din = '0;
    logic        c_rout, c_ovf;
    logic [15:0] c_dout;
`ifdef MERGE_RR_TAG_EN
    logic        a_tout;
    logic [1:0]  b_tout;
    logic [1:0]  c_tout;
`endif

    int nvec = 0;
    int nbad = 0;
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] ea, eb;

    always #5 clk = ~clk;

    merge_rr #(.N(16), .P(2), .DEPTH(2)) u_a (
        .CLK(clk), .RST(rst), .EN(a_en), .R_IN(a_rin), .D_IN(a_din),
        .R_OUT(a_rout), .D_OUT(a_dout), .OVF(a_ovf)
`ifdef MERGE_RR_TAG_EN
        , .T_OUT(a_tout)
`endif
    );

    merge_rr #(.N(16), .P(4), .DEPTH(4)) u_b (
        .CLK(clk), .RST(rst), .EN(b_en), .R_IN(b_rin), .D_IN(b_din),
        .R_OUT(b_rout), .D_OUT(b_dout), .OVF(b_ovf)
`ifdef MERGE_RR_TAG_EN
        , .T_OUT(b_tout)
`endif
    );

    merge_rr #(.N(16), .P(3), .DEPTH(2)) u_c (
        .CLK(clk), .RST(rst), .EN(c_en), .R_IN(c_rin), .D_IN(c_din),
        .R_OUT(c_rout), .D_OUT(c_dout), .OVF(c_ovf)
`ifdef MERGE_RR_TAG_EN
        , .T_OUT(c_tout)
`endif
    );

    typedef struct {
        logic        en;
        logic [1:0]  rin;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        er;
        logic [15:0] ed;
        logic        eovf;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic en, input logic [1:0] rin, input logic [15:0] d0,
                                input logic [15:0] d1, input logic er, input logic [15:0] ed,
                                input logic eovf);
        vec_t v;
        v.en = en; v.rin = rin; v.d0 = d0; v.d1 = d1; v.er = er; v.ed = ed; v.eovf = eovf;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output scoreboards: every R_OUT pulse must match the next expected token.
    always @(negedge clk) begin
        if (a_rout === 1'b1) begin
            if (qa.size() == 0) begin
                nvec++; nbad++;
                $display("FAIL sbA_unexpected: got token %0h, expected none", a_dout);
            end else begin
                ea = qa.pop_front();
                check("sbA_data", 32'(a_dout), 32'(ea));
            end
        end
        if (b_rout === 1'b1) begin
            if (qb.size() == 0) begin
                nvec++; nbad++;
                $display("FAIL sbB_unexpected: got token %0h, expected none", b_dout);
            end else begin
                eb = qb.pop_front();
                check("sbB_data", 32'(b_dout), 32'(eb));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        tbl[0]  = mk(1'b1, 2'b01, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0);
        tbl[1]  = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0);
        tbl[2]  = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h1234, 1'b0);
        tbl[3]  = mk(1'b1, 2'b10, 16'h0000, 16'h5678, 1'b0, 16'h1234, 1'b0);
        tbl[4]  = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h5678, 1'b0);
        tbl[5]  = mk(1'b1, 2'b11, 16'h000A, 16'h000B, 1'b0, 16'h5678, 1'b0);
        tbl[6]  = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h000A, 1'b0);
        tbl[7]  = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h000B, 1'b0);
        tbl[8]  = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h000B, 1'b0);
        tbl[9]  = mk(1'b1, 2'b11, 16'h00C1, 16'h00C2, 1'b0, 16'h000B, 1'b0);
        for (int i = 10; i < 15; i++)
            tbl[i] = mk(1'b0, 2'b11, 16'h00EE, 16'h00EE, 1'b0, 16'h000B, 1'b0);
        tbl[15] = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h00C1, 1'b0);
        tbl[16] = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h00C2, 1'b0);
        tbl[17] = mk(1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h00C2, 1'b0);

        #3;
        check("rst_a_rout", 32'(a_rout), 32'd0);
        check("rst_a_dout", 32'(a_dout), 32'd0);
        check("rst_a_ovf",  32'(a_ovf),  32'd0);
        check("rst_b_rout", 32'(b_rout), 32'd0);
`ifdef MERGE_RR_TAG_EN
        check("rst_c_tout", 32'(c_tout), 32'd0);
`endif
        #9 rst = 1'b0;

        // Single token, simultaneous arrival and freeze, cycle by cycle.
        for (int i = 0; i < 18; i++) begin
            a_en  = tbl[i].en;
            a_rin = tbl[i].rin;
            a_din = {tbl[i].d1, tbl[i].d0};
            if (tbl[i].er) qa.push_back(tbl[i].ed);
            tick();
            check($sformatf("row%0d_rout", i), 32'(a_rout), 32'(tbl[i].er));
            check($sformatf("row%0d_dout", i), 32'(a_dout), 32'(tbl[i].ed));
            check($sformatf("row%0d_ovf", i),  32'(a_ovf),  32'(tbl[i].eovf));
        end
        a_en = 1'b1; a_rin = 2'b00;

        // Move ptr to lane 1, then overload both lanes: lane 0's a3 is dropped.
        a_rin = 2'b01; a_din = {16'h0000, 16'h0300}; qa.push_back(16'h0300);
        tick();
        a_rin = 2'b00;
        tick(); tick();
        qa.push_back(16'h0B00); qa.push_back(16'h0A00); qa.push_back(16'h0B01);
        qa.push_back(16'h0A01); qa.push_back(16'h0B02); qa.push_back(16'h0A02);
        qa.push_back(16'h0B03);
        for (int i = 0; i < 4; i++) begin
            a_rin = 2'b11;
            a_din = {16'h0B00 + 16'(i), 16'h0A00 + 16'(i)};
            tick();
            check($sformatf("ovf_e%0d", i), 32'(a_ovf), (i == 3) ? 32'd1 : 32'd0);
        end
        a_rin = 2'b00;
        repeat (6) tick();
        check("ovf_sticky", 32'(a_ovf), 32'd1);
        check("ovf_drain",  32'(qa.size()), 32'd0);

        // Asynchronous reset mid-stream with tokens queued.
        a_rin = 2'b11; a_din = {16'h0D01, 16'h0D00};
        tick();
        a_rin = 2'b00;
        #2 rst = 1'b1;
        qa.delete();
        #1;
        check("arst_rout", 32'(a_rout), 32'd0);
        check("arst_dout", 32'(a_dout), 32'd0);
        check("arst_ovf",  32'(a_ovf),  32'd0);
        #2 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_rout) cnt++;
        end
        check("arst_stale", 32'(cnt), 32'd0);
        a_rin = 2'b11; a_din = {16'h0F01, 16'h0F00};
        qa.push_back(16'h0F00); qa.push_back(16'h0F01);
        tick();
        a_rin = 2'b00;
        repeat (3) tick();
        check("arst_drain", 32'(qa.size()), 32'd0);
        check("arst_ovf_after", 32'(a_ovf), 32'd0);

        // Fairness: four lanes, four tokens each.
        for (int j = 0; j < 4; j++) begin
            b_rin = 4'hF;
            for (int l = 0; l < 4; l++) begin
                b_din[l*16 +: 16] = 16'((l << 8) | j);
                qb.push_back(16'((l << 8) | j));
            end
            tick();
            check($sformatf("fair_in%0d_rout", j), 32'(b_rout), (j > 0) ? 32'd1 : 32'd0);
        end
        b_rin = 4'h0;
        for (int k = 0; k < 13; k++) begin
            tick();
            check($sformatf("fair_run%0d_rout", k), 32'(b_rout), 32'd1);
        end
        tick();
        check("fair_end_rout", 32'(b_rout), 32'd0);
        check("fair_drain", 32'(qb.size()), 32'd0);
        check("fair_ovf", 32'(b_ovf), 32'd0);

        // Three lanes, tokens on lanes 2 and 0 together.
        c_rin = 3'b101; c_din = {16'h0C02, 16'h0C01, 16'h0C00};
        tick();
        c_rin = 3'b000;
        tick();
        check("tag_first_rout", 32'(c_rout), 32'd1);
        check("tag_first_dout", 32'(c_dout), 32'h0C00);
`ifdef MERGE_RR_TAG_EN
        check("tag_first_tout", 32'(c_tout), 32'd0);
`endif
        tick();
        check("tag_second_rout", 32'(c_rout), 32'd1);
        check("tag_second_dout", 32'(c_dout), 32'h0C02);
`ifdef MERGE_RR_TAG_EN
        check("tag_second_tout", 32'(c_tout), 32'd2);
`endif
        tick();
        check("tag_idle_rout", 32'(c_rout), 32'd0);
`ifdef MERGE_RR_TAG_EN
        check("tag_idle_tout", 32'(c_tout), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
